// File: rtl/pipeline_trace_collector_pkg.sv
// Shared types and constants for the pipeline trace collector: stage numbering,
// record layout and the set-stage scan used by the serializer.
package trace_pkg;

    typedef enum logic [2:0] {
        STAGE_FETCH  = 3'd0,
        STAGE_DECODE = 3'd1,
        STAGE_RENAME = 3'd2,
        STAGE_ISSUE  = 3'd3,
        STAGE_COMMIT = 3'd4
    } trace_stage_e;

    localparam int unsigned WORDS_PER_STAGE = 6;
    localparam int unsigned NUM_STAGES      = 5;
    localparam int unsigned HDR_TS_WIDTH    = 22;
    localparam logic [3:0]  HDR_MAGIC       = 4'hA;

    typedef struct packed {
        logic                                             lost;
        logic [NUM_STAGES-1:0]                            mask;
        logic [HDR_TS_WIDTH-1:0]                          ts;
        logic [NUM_STAGES-1:0][WORDS_PER_STAGE-1:0][31:0] payload;
    } trace_record_t;

    // Lowest set stage at or above 'from'; returns NUM_STAGES when none remain.
    function automatic logic [2:0] next_stage(input logic [NUM_STAGES-1:0] mask,
                                              input logic [2:0] from);
        logic [NUM_STAGES-1:0] m;
        m = mask & ~(5'((6'd1 << from) - 6'd1));
        casez (m)
            5'b????1: return 3'd0;
            5'b???10: return 3'd1;
            5'b??100: return 3'd2;
            5'b?1000: return 3'd3;
            5'b10000: return 3'd4;
            default:  return 3'(NUM_STAGES);
        endcase
    endfunction

endpackage

// File: rtl/pipeline_trace_collector_fifo.sv
// Synchronous record FIFO; a push is accepted at full when a pop happens in
// the same cycle.
module trace_record_fifo
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  trace_record_t            push_data,
    input  logic                     pop,
    output trace_record_t            pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    trace_record_t   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    always_comb begin
        full     = (level == LW'(DEPTH));
        empty    = (level == '0);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        pop_data = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pipeline_trace_collector.sv
// Captures per-stage pipeline events as timestamped records and streams them
// out as 32-bit words: header, then six words per flagged stage.
module pipeline_trace_collector
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TS_WIDTH = 22
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        trace_enable,
    input  logic [4:0]                  ev_valid,
    input  logic [4:0][5:0][31:0]       ev_word,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_data,
    output logic                        out_last,
    output logic [15:0]                 dropped_count,
    output logic [$clog2(DEPTH):0]      fifo_level
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, HDR, STG} ser_state_e;

    ser_state_e          state_q;
    logic [TS_WIDTH-1:0] ts_q;
    logic                loss_pending_q;
    logic [2:0]          stage_q;
    logic [2:0]          word_q;
    logic [2:0]          nxt_stage;
    logic                last_stage;
    logic                capture;
    logic                pop;
    logic                push;
    logic                full;
    logic                empty;
    trace_record_t       new_rec;
    trace_record_t       head;

    always_comb begin
        capture        = trace_enable && (ev_valid != '0);
        pop            = out_valid && out_ready && out_last;
        push           = capture && (!full || pop);
        new_rec.lost    = loss_pending_q;
        new_rec.mask    = ev_valid;
        new_rec.ts      = HDR_TS_WIDTH'(ts_q);
        new_rec.payload = ev_word;
        nxt_stage      = next_stage(head.mask, stage_q + 3'd1);
        last_stage     = (nxt_stage == 3'(NUM_STAGES));
    end

    trace_record_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (new_rec),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q           <= '0;
            loss_pending_q <= 1'b0;
            dropped_count  <= '0;
        end else begin
            ts_q <= ts_q + TS_WIDTH'(1);
            if (push) begin
                loss_pending_q <= 1'b0;
            end else if (capture) begin
                loss_pending_q <= 1'b1;
                if (dropped_count != '1) dropped_count <= dropped_count + 16'd1;
            end
        end
    end

    // Word data is muxed straight from the FIFO head so a record pushed into an
    // empty collector can present its header on the very next cycle.
    always_comb begin
        out_data = '0;
        case (state_q)
            HDR:     out_data = {HDR_MAGIC, head.lost, head.mask, head.ts};
            STG:     out_data = head.payload[stage_q][word_q];
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            stage_q   <= '0;
            word_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (push || !empty) begin
                        state_q   <= HDR;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                    end
                end
                HDR: begin
                    if (out_ready) begin
                        state_q  <= STG;
                        stage_q  <= next_stage(head.mask, 3'd0);
                        word_q   <= '0;
                        out_last <= 1'b0;
                    end
                end
                STG: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_last <= 1'b0;
                            if (push || fifo_level > LW'(1)) begin
                                state_q   <= HDR;
                                out_valid <= 1'b1;
                            end else begin
                                state_q   <= IDLE;
                                out_valid <= 1'b0;
                            end
                        end else if (word_q != 3'(WORDS_PER_STAGE - 1)) begin
                            word_q   <= word_q + 3'd1;
                            out_last <= (word_q == 3'(WORDS_PER_STAGE - 2)) && last_stage;
                        end else begin
                            stage_q  <= nxt_stage;
                            word_q   <= '0;
                            out_last <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule
